nf10_rr_input_arbiter: RTL and testbench

Merges NUM_QUEUES slave AXI4-Stream ingress ports (MAC/DMA RX paths) into one master stream toward the datapath (lookup, then output queues). Arbitration is packet-granular round-robin: once granted, an input keeps the output until its tlast beat is accepted. Emits per-input forwarded-packet and forwarded-word pulses for the stats register block.

---
 rtl/nf10_rr_input_arbiter_pkg.sv | 31 +++
 rtl/nf10_rr_input_arbiter_grant.sv | 24 ++
 rtl/nf10_rr_input_arbiter.sv | 172 +++++++++++++++++
 tb/tb_nf10_rr_input_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_rr_input_arbiter_pkg.sv
// Shared types and constants for the NetFPGA-10G round-robin input arbiter.
// Defines the arbiter state enum, the queue index type and the tuser header field offsets.
// Also provides the modular pointer increment used by the grant logic and the top level.
package nf10_arb_pkg;

   localparam int NQ_FIXED     = 5;
   localparam int NUM_QUEUES_W = $clog2(NQ_FIXED);

   // tuser header layout: len[15:0], src[23:16], dst[31:24]
   localparam int TUSER_LEN_LSB = 0;
   localparam int TUSER_LEN_W   = 16;
   localparam int TUSER_SRC_LSB = 16;
   localparam int TUSER_SRC_W   = 8;
   localparam int TUSER_DST_LSB = 24;
   localparam int TUSER_DST_W   = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   typedef logic [NUM_QUEUES_W-1:0] qidx_t;

   // (p + k) mod NQ_FIXED; p is always a legal queue index
   function automatic qidx_t rr_add(input qidx_t p, input int unsigned k);
      int unsigned s;
      s = 32'(p) + k;
      return qidx_t'(s % NQ_FIXED);
   endfunction

endpackage

// File: rtl/nf10_rr_input_arbiter_grant.sv
// Rotating priority encoder: first requester at or after ptr, wrapping modulo the queue count.
// Latency: purely combinational.
// Backpressure: none; any_req reports whether the grant index is meaningful.
module nf10_rr_grant
   import nf10_arb_pkg::*;
(
   input  logic [NQ_FIXED-1:0] req,
   input  qidx_t               ptr,
   output qidx_t               grant,
   output logic                any_req
);

   // Scan from farthest to nearest so the requester closest to ptr wins last
   always_comb begin
      grant   = ptr;
      any_req = |req;
      for (int k = NQ_FIXED - 1; k >= 0; k--) begin
         if (req[rr_add(ptr, 32'(k))]) begin
            grant = rr_add(ptr, 32'(k));
         end
      end
   end

endmodule

// File: rtl/nf10_rr_input_arbiter.sv
// Merges five AXI4-Stream inputs into one, packet-granular round-robin with per-input stats pulses.
// Latency: zero-latency data mux; stats pulses registered one cycle after the handshake.
// Backpressure: m_axis_tready passes straight to the granted input only; one idle cycle after each multi-beat packet.
module nf10_rr_input_arbiter
   import nf10_arb_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int NUM_QUEUES           = NQ_FIXED
) (
   input  logic                               axi_aclk,
   input  logic                               axi_resetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata_0,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb_0,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser_0,
   input  logic                               s_axis_tvalid_0,
   output logic                               s_axis_tready_0,
   input  logic                               s_axis_tlast_0,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata_1,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb_1,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser_1,
   input  logic                               s_axis_tvalid_1,
   output logic                               s_axis_tready_1,
   input  logic                               s_axis_tlast_1,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata_2,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb_2,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser_2,
   input  logic                               s_axis_tvalid_2,
   output logic                               s_axis_tready_2,
   input  logic                               s_axis_tlast_2,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata_3,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb_3,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser_3,
   input  logic                               s_axis_tvalid_3,
   output logic                               s_axis_tready_3,
   input  logic                               s_axis_tlast_3,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata_4,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb_4,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser_4,
   input  logic                               s_axis_tvalid_4,
   output logic                               s_axis_tready_4,
   input  logic                               s_axis_tlast_4,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
   output logic                               m_axis_tvalid,
   input  logic                               m_axis_tready,
   output logic                               m_axis_tlast,
   output logic [NUM_QUEUES-1:0]              pkt_fwd,
   output logic [NUM_QUEUES-1:0]              word_fwd
);

   logic [C_S_AXIS_DATA_WIDTH-1:0]   s_dat [NUM_QUEUES];
   logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_stb [NUM_QUEUES];
   logic [C_S_AXIS_TUSER_WIDTH-1:0]  s_usr [NUM_QUEUES];
   logic [NUM_QUEUES-1:0]            s_vld;
   logic [NUM_QUEUES-1:0]            s_lst;
   logic [NUM_QUEUES-1:0]            s_rdy;

   arb_state_t            state_q, state_d;
   qidx_t                 cur_q, cur_d;
   qidx_t                 rr_ptr_q, rr_ptr_d;
   logic                  gap_q, gap_d;
   logic [NUM_QUEUES-1:0] word_fwd_q, word_fwd_d;
   logic [NUM_QUEUES-1:0] pkt_fwd_q, pkt_fwd_d;

   qidx_t rr_grant;
   logic  any_req;
   qidx_t sel;
   logic  sel_valid;
   logic  sel_last;
   logic  hs;

   assign s_dat = '{s_axis_tdata_0, s_axis_tdata_1, s_axis_tdata_2, s_axis_tdata_3, s_axis_tdata_4};
   assign s_stb = '{s_axis_tstrb_0, s_axis_tstrb_1, s_axis_tstrb_2, s_axis_tstrb_3, s_axis_tstrb_4};
   assign s_usr = '{s_axis_tuser_0, s_axis_tuser_1, s_axis_tuser_2, s_axis_tuser_3, s_axis_tuser_4};
   assign s_vld = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
   assign s_lst = {s_axis_tlast_4, s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};

   nf10_rr_grant u_grant (
      .req     (s_vld),
      .ptr     (rr_ptr_q),
      .grant   (rr_grant),
      .any_req (any_req)
   );

   // Source selection: locked input owns the output; otherwise the round-robin winner,
   // held off for the one cycle right after a locked packet ends
   always_comb begin
      sel       = rr_grant;
      sel_valid = any_req & ~gap_q;
      if (state_q == LOCKED) begin
         sel       = cur_q;
         sel_valid = s_vld[cur_q];
      end
   end

   assign sel_last = s_lst[sel];
   assign hs       = sel_valid & m_axis_tready;

   assign m_axis_tdata  = s_dat[sel];
   assign m_axis_tstrb  = s_stb[sel];
   assign m_axis_tuser  = s_usr[sel];
   assign m_axis_tlast  = sel_last;
   // Reset gates the handshake outputs immediately, before any clock edge
   assign m_axis_tvalid = sel_valid & axi_resetn;

   // Ready goes only to the selected input, and only when the beat will be taken
   always_comb begin
      s_rdy = '0;
      if (hs && axi_resetn) begin
         s_rdy[sel] = 1'b1;
      end
   end

   assign s_axis_tready_0 = s_rdy[0];
   assign s_axis_tready_1 = s_rdy[1];
   assign s_axis_tready_2 = s_rdy[2];
   assign s_axis_tready_3 = s_rdy[3];
   assign s_axis_tready_4 = s_rdy[4];

   // Next-state: lock on a non-final beat, release and advance the pointer on tlast
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      rr_ptr_d   = rr_ptr_q;
      gap_d      = 1'b0;
      word_fwd_d = '0;
      pkt_fwd_d  = '0;
      if (hs) begin
         word_fwd_d[sel] = 1'b1;
         pkt_fwd_d[sel]  = sel_last;
         if (state_q == IDLE) begin
            if (sel_last) begin
               rr_ptr_d = rr_add(sel, 32'd1);
            end else begin
               state_d = LOCKED;
               cur_d   = sel;
            end
         end else if (sel_last) begin
            state_d  = IDLE;
            rr_ptr_d = rr_add(cur_q, 32'd1);
            gap_d    = 1'b1;
         end
      end
   end

   // State and stats registers; reset abandons any packet in flight
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q    <= IDLE;
         cur_q      <= '0;
         rr_ptr_q   <= '0;
         gap_q      <= 1'b0;
         word_fwd_q <= '0;
         pkt_fwd_q  <= '0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         rr_ptr_q   <= rr_ptr_d;
         gap_q      <= gap_d;
         word_fwd_q <= word_fwd_d;
         pkt_fwd_q  <= pkt_fwd_d;
      end
   end

   assign word_fwd = word_fwd_q;
   assign pkt_fwd  = pkt_fwd_q;

endmodule

// File: tb/tb_nf10_rr_input_arbiter.sv
// Directed bench for the round-robin input arbiter: cycle tables plus an async-reset sequence.
// Inputs driven just after the rising edge, outputs compared on the falling edge.
// Each input's data carries {queue, beat}; the beat advances when the table expects a handshake.
module tb_nf10_rr_input_arbiter;
   import nf10_arb_pkg::*;

   localparam int DW = 256;
   localparam int UW = 128;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [4:0] tb_vld = '0;
   logic [4:0] tb_lst = '0;
   logic       m_rdy = 1'b0;
   int         beat [5];

   logic [DW-1:0]   m_tdata;
   logic [DW/8-1:0] m_tstrb;
   logic [UW-1:0]   m_tuser;
   logic            m_tvalid, m_tlast;
   logic [4:0]      pkt_fwd, word_fwd, trdy;
   logic [4:0]      rdy_i;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk_dat(input int q, input int b);
      logic [DW-1:0] d;
      d = '0;
      d[15:8] = 8'(q);
      d[7:0]  = 8'(b);
      d[DW-1:DW-8] = 8'hA5;
      return d;
   endfunction

   function automatic logic [UW-1:0] mk_usr(input int q);
      logic [UW-1:0] u;
      u = '0;
      u[TUSER_LEN_LSB +: TUSER_LEN_W] = 16'(64 + q);
      u[TUSER_SRC_LSB +: TUSER_SRC_W] = 8'(q);
      u[TUSER_DST_LSB +: TUSER_DST_W] = 8'(8'hD0 + q);
      return u;
   endfunction

   nf10_rr_input_arbiter dut (
      .axi_aclk        (clk),
      .axi_resetn      (rst_n),
      .s_axis_tdata_0  (mk_dat(0, beat[0])), .s_axis_tstrb_0 ({(DW/8){1'b1}}), .s_axis_tuser_0 (mk_usr(0)),
      .s_axis_tvalid_0 (tb_vld[0]), .s_axis_tready_0 (rdy_i[0]), .s_axis_tlast_0 (tb_lst[0]),
      .s_axis_tdata_1  (mk_dat(1, beat[1])), .s_axis_tstrb_1 ({(DW/8){1'b1}}), .s_axis_tuser_1 (mk_usr(1)),
      .s_axis_tvalid_1 (tb_vld[1]), .s_axis_tready_1 (rdy_i[1]), .s_axis_tlast_1 (tb_lst[1]),
      .s_axis_tdata_2  (mk_dat(2, beat[2])), .s_axis_tstrb_2 ({(DW/8){1'b1}}), .s_axis_tuser_2 (mk_usr(2)),
      .s_axis_tvalid_2 (tb_vld[2]), .s_axis_tready_2 (rdy_i[2]), .s_axis_tlast_2 (tb_lst[2]),
      .s_axis_tdata_3  (mk_dat(3, beat[3])), .s_axis_tstrb_3 ({(DW/8){1'b1}}), .s_axis_tuser_3 (mk_usr(3)),
      .s_axis_tvalid_3 (tb_vld[3]), .s_axis_tready_3 (rdy_i[3]), .s_axis_tlast_3 (tb_lst[3]),
      .s_axis_tdata_4  (mk_dat(4, beat[4])), .s_axis_tstrb_4 ({(DW/8){1'b1}}), .s_axis_tuser_4 (mk_usr(4)),
      .s_axis_tvalid_4 (tb_vld[4]), .s_axis_tready_4 (rdy_i[4]), .s_axis_tlast_4 (tb_lst[4]),
      .m_axis_tdata    (m_tdata),
      .m_axis_tstrb    (m_tstrb),
      .m_axis_tuser    (m_tuser),
      .m_axis_tvalid   (m_tvalid),
      .m_axis_tready   (m_rdy),
      .m_axis_tlast    (m_tlast),
      .pkt_fwd         (pkt_fwd),
      .word_fwd        (word_fwd)
   );

   assign trdy = rdy_i;

   typedef struct {
      logic       rst;
      logic [4:0] vld;
      logic [4:0] lst;
      logic       rdy;
      logic       e_vld;
      int         e_src;
      logic       e_last;
      logic [4:0] e_trdy;
      logic [4:0] e_word;
      logic [4:0] e_pkt;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic [4:0] v, input logic [4:0] l, input logic rd,
                      input logic ev, input int es, input logic el,
                      input logic [4:0] et, input logic [4:0] ew, input logic [4:0] ep);
      vec_t t;
      t = '{r, v, l, rd, ev, es, el, et, ew, ep};
      vq.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      tb_vld = '0;
      tb_lst = '0;
      rst_n  = 1'b0;
      for (int i = 0; i < 5; i++) beat[i] = 0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 5; i++) beat[i] = 0;

      // Scenario 1: input 2 sends a 3-beat packet
      add(1, 5'b00000, 5'b00000, 1, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
      add(0, 5'b00100, 5'b00000, 1, 1, 2, 0, 5'b00100, 5'b00000, 5'b00000);
      add(0, 5'b00100, 5'b00000, 1, 1, 2, 0, 5'b00100, 5'b00100, 5'b00000);
      add(0, 5'b00100, 5'b00100, 1, 1, 2, 1, 5'b00100, 5'b00100, 5'b00000);
      add(0, 5'b00000, 5'b00000, 1, 0, 0, 0, 5'b00000, 5'b00100, 5'b00100);
      add(0, 5'b00000, 5'b00000, 1, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
      // Scenario 2: inputs 0,1,3 each hold a 2-beat packet, order 0,1,3 with a bubble between
      add(1, 5'b01011, 5'b00000, 1, 1, 0, 0, 5'b00001, 5'b00000, 5'b00000);
      add(0, 5'b01011, 5'b00001, 1, 1, 0, 1, 5'b00001, 5'b00001, 5'b00000);
      add(0, 5'b01010, 5'b00000, 1, 0, 0, 0, 5'b00000, 5'b00001, 5'b00001);
      add(0, 5'b01010, 5'b00000, 1, 1, 1, 0, 5'b00010, 5'b00000, 5'b00000);
      add(0, 5'b01010, 5'b00010, 1, 1, 1, 1, 5'b00010, 5'b00010, 5'b00000);
      add(0, 5'b01000, 5'b00000, 1, 0, 0, 0, 5'b00000, 5'b00010, 5'b00010);
      add(0, 5'b01000, 5'b00000, 1, 1, 3, 0, 5'b01000, 5'b00000, 5'b00000);
      add(0, 5'b01000, 5'b01000, 1, 1, 3, 1, 5'b01000, 5'b01000, 5'b00000);
      add(0, 5'b00000, 5'b00000, 1, 0, 0, 0, 5'b00000, 5'b01000, 5'b01000);
      // Scenario 3: pointer now 4; inputs 4 and 0 -> 4 then 0 (wrap); pointer 1 -> 4 still first
      add(0, 5'b10001, 5'b10001, 1, 1, 4, 1, 5'b10000, 5'b00000, 5'b00000);
      add(0, 5'b00001, 5'b00001, 1, 1, 0, 1, 5'b00001, 5'b10000, 5'b10000);
      add(0, 5'b00000, 5'b00000, 1, 0, 0, 0, 5'b00000, 5'b00001, 5'b00001);
      add(0, 5'b10001, 5'b10001, 1, 1, 4, 1, 5'b10000, 5'b00000, 5'b00000);
      add(0, 5'b00001, 5'b00001, 1, 1, 0, 1, 5'b00001, 5'b10000, 5'b10000);
      add(0, 5'b00000, 5'b00000, 1, 0, 0, 0, 5'b00000, 5'b00001, 5'b00001);
      // Scenario 4: input 1 sends 4 beats under tready 1,0,0,1,1,0,1; input 3 waits throughout
      add(1, 5'b01010, 5'b01000, 1, 1, 1, 0, 5'b00010, 5'b00000, 5'b00000);
      add(0, 5'b01010, 5'b01000, 0, 1, 1, 0, 5'b00000, 5'b00010, 5'b00000);
      add(0, 5'b01010, 5'b01000, 0, 1, 1, 0, 5'b00000, 5'b00000, 5'b00000);
      add(0, 5'b01010, 5'b01000, 1, 1, 1, 0, 5'b00010, 5'b00000, 5'b00000);
      add(0, 5'b01010, 5'b01000, 1, 1, 1, 0, 5'b00010, 5'b00010, 5'b00000);
      add(0, 5'b01010, 5'b01010, 0, 1, 1, 1, 5'b00000, 5'b00010, 5'b00000);
      add(0, 5'b01010, 5'b01010, 1, 1, 1, 1, 5'b00010, 5'b00000, 5'b00000);
      add(0, 5'b01000, 5'b01000, 1, 0, 0, 0, 5'b00000, 5'b00010, 5'b00010);
      add(0, 5'b01000, 5'b01000, 1, 1, 3, 1, 5'b01000, 5'b00000, 5'b00000);
      add(0, 5'b00000, 5'b00000, 1, 0, 0, 0, 5'b00000, 5'b01000, 5'b01000);
      // Scenario 5: all inputs stream single-beat packets, one per cycle in rotation
      add(1, 5'b11111, 5'b11111, 1, 1, 0, 1, 5'b00001, 5'b00000, 5'b00000);
      add(0, 5'b11111, 5'b11111, 1, 1, 1, 1, 5'b00010, 5'b00001, 5'b00001);
      add(0, 5'b11111, 5'b11111, 1, 1, 2, 1, 5'b00100, 5'b00010, 5'b00010);
      add(0, 5'b11111, 5'b11111, 1, 1, 3, 1, 5'b01000, 5'b00100, 5'b00100);
      add(0, 5'b11111, 5'b11111, 1, 1, 4, 1, 5'b10000, 5'b01000, 5'b01000);
      add(0, 5'b11111, 5'b11111, 1, 1, 0, 1, 5'b00001, 5'b10000, 5'b10000);
      add(0, 5'b11111, 5'b11111, 1, 1, 1, 1, 5'b00010, 5'b00001, 5'b00001);
      add(0, 5'b00000, 5'b00000, 1, 0, 0, 0, 5'b00000, 5'b00010, 5'b00010);

      // Outputs gated while reset is held, even with every input valid
      rst_n  = 1'b0;
      tb_vld = 5'b11111;
      m_rdy  = 1'b1;
      #3;
      chk("in_reset tvalid", DW'(m_tvalid), DW'(1'b0));
      chk("in_reset tready", DW'(trdy), DW'(5'b00000));
      @(posedge clk);
      #1;

      foreach (vq[n]) begin
         if (vq[n].rst) do_reset();
         tb_vld = vq[n].vld;
         tb_lst = vq[n].lst;
         m_rdy  = vq[n].rdy;
         @(negedge clk);
         chk($sformatf("row%0d tvalid", n), DW'(m_tvalid), DW'(vq[n].e_vld));
         chk($sformatf("row%0d tready", n), DW'(trdy), DW'(vq[n].e_trdy));
         chk($sformatf("row%0d word_fwd", n), DW'(word_fwd), DW'(vq[n].e_word));
         chk($sformatf("row%0d pkt_fwd", n), DW'(pkt_fwd), DW'(vq[n].e_pkt));
         if (vq[n].e_vld) begin
            chk($sformatf("row%0d tdata", n), m_tdata, mk_dat(vq[n].e_src, beat[vq[n].e_src]));
            chk($sformatf("row%0d tlast", n), DW'(m_tlast), DW'(vq[n].e_last));
         end
         for (int i = 0; i < 5; i++) begin
            if (vq[n].vld[i] && vq[n].e_trdy[i]) beat[i]++;
         end
         @(posedge clk);
         #1;
      end

      // Async reset mid-packet on input 2, then a fresh packet on input 2
      do_reset();
      tb_vld = 5'b00100;
      tb_lst = 5'b00000;
      m_rdy  = 1'b1;
      @(negedge clk);
      chk("rst_seq first beat tready", DW'(trdy), DW'(5'b00100));
      @(posedge clk);
      #1;
      beat[2] = 1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_seq async tvalid", DW'(m_tvalid), DW'(1'b0));
      chk("rst_seq async tready", DW'(trdy), DW'(5'b00000));
      chk("rst_seq async word_fwd", DW'(word_fwd), DW'(5'b00000));
      chk("rst_seq async pkt_fwd", DW'(pkt_fwd), DW'(5'b00000));
      @(posedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      beat[2] = 0;
      tb_vld  = 5'b00001;
      tb_lst  = 5'b00001;
      #1;
      chk("rst_seq idle grant0 tvalid", DW'(m_tvalid), DW'(1'b1));
      chk("rst_seq idle grant0 tready", DW'(trdy), DW'(5'b00001));
      chk("rst_seq idle grant0 tdata", m_tdata, mk_dat(0, 0));
      @(posedge clk);
      #1;
      tb_vld = 5'b00100;
      tb_lst = 5'b00000;
      @(negedge clk);
      chk("rst_seq new pkt tvalid", DW'(m_tvalid), DW'(1'b1));
      chk("rst_seq new pkt tready", DW'(trdy), DW'(5'b00100));
      chk("rst_seq new pkt tdata", m_tdata, mk_dat(2, 0));
      chk("rst_seq hdr len", DW'(m_tuser[TUSER_LEN_LSB +: TUSER_LEN_W]), DW'(16'd66));
      chk("rst_seq hdr src", DW'(m_tuser[TUSER_SRC_LSB +: TUSER_SRC_W]), DW'(8'd2));
      chk("rst_seq hdr dst", DW'(m_tuser[TUSER_DST_LSB +: TUSER_DST_W]), DW'(8'hD2));
      chk("rst_seq word after grant0", DW'(word_fwd), DW'(5'b00001));
      @(posedge clk);
      #1;
      tb_vld = 5'b00000;
      @(negedge clk);
      chk("rst_seq word after new pkt", DW'(word_fwd), DW'(5'b00100));
      chk("rst_seq no pkt pulse", DW'(pkt_fwd), DW'(5'b00000));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
